uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- UART receiver for the board's serial input pin: 8 data bits, LSB first, 1 start bit, 1 stop bit, 16x oversampling.
- Sits between the UART_RXD board pin and user logic in the DE2 top level. It is the receive-side counterpart of the UART_TXD transmit path.
- Delivers bytes through a one-entry holding register with a valid/acknowledge handshake, and reports framing and overrun errors.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- OVERSAMPLE, 16, ticks per bit; fixed at 16, other values unsupported.
- DIV, CLK_HZ/(BAUD*OVERSAMPLE) integer-truncated (27 at defaults), derived, must be >= 1.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- UART_RXD  in  1  asynchronous serial line; idles high.
- RX_DATA  out  8  received byte; stable while RX_VALID=1.
- RX_VALID  out  1  holding register full; held high until acknowledged.
- RX_ACK  in  1  consumer takes the byte; meaningful only while RX_VALID=1.
- RX_FRAME_ERR  out  1  one-cycle pulse when the stop bit is sampled low.
- RX_OVERRUN  out  1  sticky; a byte was lost because the holding register was full.
- RX_BUSY  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- **Input synchronizer.** UART_RXD passes through a 2-FF synchronizer that resets to 1. All logic uses the synchronized value rxs.
- **Tick generator.** Counter runs 0..DIV-1 and pulses tick for one clock when it reaches DIV-1. It restarts at 0 on the IDLE->START transition so start-bit timing is aligned.
- **State machine:** IDLE, START, DATA, STOP, WAIT_IDLE (all in uart_pkg).
  - IDLE: when rxs=0, go to START and clear the sample counter scnt (4 bits).
  - START: count ticks. At scnt=7 (mid start bit):
    - rxs=1 → false start, return to IDLE with no error reported;
    - rxs=0 → clear scnt and go to DATA with bit index 0.
  - DATA: sample rxs on every 16th tick (scnt=15 wraps), shifting it into the MSB of the shift register (LSB-first line order). After bit index 7, go to STOP.
  - STOP: sample on the 16th tick (mid stop bit).
    - rxs=1 → commit the byte (see handshake) and go to IDLE. A new start bit can then be detected half a bit early.
    - rxs=0 → pulse RX_FRAME_ERR, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE (break/line-low recovery): stay until rxs=1, then go to IDLE.
- **Handshake and commit.**
  - A commit loads RX_DATA and sets RX_VALID=1 on the next edge if RX_VALID=0, or if RX_ACK=1 in the same cycle (simultaneous ack and commit: the new byte replaces the old, RX_VALID stays 1).
  - Commit while RX_VALID=1 and RX_ACK=0: the new byte is dropped, RX_DATA is unchanged, RX_OVERRUN is set.
  - RX_ACK=1 while RX_VALID=1 with no commit: RX_VALID clears next edge and RX_OVERRUN clears.
  - RX_ACK while RX_VALID=0 is ignored.
- **Latency.** RX_VALID rises exactly 1 clock after the tick that samples the stop bit.
- **Reset values:** RX_DATA=8'h00, RX_VALID=0, RX_FRAME_ERR=0, RX_OVERRUN=0, RX_BUSY=0, state=IDLE, counters=0.
- **Reset mid-frame.** Asynchronous reset mid-frame aborts it. After release, if the line is mid-byte, the next low bit is treated as a start bit. A resulting framing error is acceptable.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - adds parameter PARITY_ODD (default 0 = even) and output RX_PARITY_ERR (out, 1, one-cycle pulse);
  - inserts a PARITY state between DATA and STOP, sampled mid-bit;
  - on mismatch, RX_PARITY_ERR pulses together with the STOP-state decision, and the byte is discarded, not committed.
- When undefined: no PARITY state, no port, frame is 10 bits.

Decomposition:
- Package uart_pkg holds:
  - state enum (rx_state_t);
  - OVERSAMPLE=16;
  - MID_SAMPLE=7;
  - DATA_BITS=8;
  - helper function for computing DIV.
- Sub-module uart_baud_tick: tick generator with DIV parameter, inputs CLOCK_50, RESET_N, restart, output tick. It is reusable by the transmit side.
- FSM, shift register and handshake stay in uart_rx_core.

Test Plan:
- Run all scenarios with CLK_HZ=1600000, BAUD=100000 (DIV=1, 16 clocks/bit).
- Send 0xA5 with RX_ACK tied 0 → RX_DATA=8'hA5 and RX_VALID=1 within 1 clock after mid-stop; RX_FRAME_ERR=0, RX_OVERRUN=0.
- Send 0x3C, then 0x81 with no ACK → RX_DATA stays 8'h3C, RX_OVERRUN=1. Pulse RX_ACK → RX_VALID=0, RX_OVERRUN=0.
- Drive UART_RXD low for 4 clocks only → FSM returns to IDLE, RX_BUSY falls, no RX_VALID, no RX_FRAME_ERR.
- Send 0x55 with the stop bit forced low, then hold the line low 40 clocks → one RX_FRAME_ERR pulse, RX_VALID stays 0, FSM stays in WAIT_IDLE until the line goes high. A following 0x0F is received correctly.
- Assert RESET_N=0 during data bit 3 of 0xFF → all outputs return to reset values asynchronously. After release and idle, 0x12 is received correctly.
- With UART_RX_PARITY_EN and PARITY_ODD=0: send 0x07 with the parity bit 0 → RX_PARITY_ERR pulse, no commit. With the parity bit 1 → RX_DATA=8'h07 committed.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive/transmit paths.
// Contents: rx_state_t FSM encoding, oversampling constants, baud divisor helper.
// Optional feature macro: UART_RX_PARITY_EN (adds the ST_PARITY state).
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned MID_SAMPLE = 7;
   localparam int unsigned DATA_BITS  = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP,
      ST_WAIT_IDLE
   } rx_state_t;

   // Clocks per oversample tick; clamped so a too-fast baud still yields a legal divider.
   function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
      int unsigned d;
      d = clk_hz / (baud * OVERSAMPLE);
      return (d == 0) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-clock tick every DIV clocks.
// Ports: CLOCK_50 (clk), RESET_N (async active-low), restart (realign counter to 0),
//        tick (high for one clock when the counter is at DIV-1).
module uart_baud_tick #(
   parameter int unsigned DIV = 27
) (
   input  logic CLOCK_50,
   input  logic RESET_N,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: wrap at DIV-1, or realign on restart.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart || (cnt_q == CW'(DIV - 1))) cnt_d = '0;
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with 16x oversampling and a one-entry holding register.
// Ports: CLOCK_50/RESET_N clock and async active-low reset; UART_RXD serial input (idle high);
//        RX_DATA/RX_VALID/RX_ACK byte handshake; RX_FRAME_ERR one-cycle pulse on bad stop bit;
//        RX_OVERRUN sticky lost-byte flag; RX_BUSY high whenever not idle.
// Optional feature macro: UART_RX_PARITY_EN adds PARITY_ODD and RX_PARITY_ERR (one-cycle pulse).
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50000000,
   parameter int unsigned BAUD   = 115200
`ifdef UART_RX_PARITY_EN
   , parameter bit        PARITY_ODD = 1'b0
`endif
) (
   input  logic                 CLOCK_50,
   input  logic                 RESET_N,
   input  logic                 UART_RXD,
   output logic [DATA_BITS-1:0] RX_DATA,
   output logic                 RX_VALID,
   input  logic                 RX_ACK,
   output logic                 RX_FRAME_ERR,
   output logic                 RX_OVERRUN,
   output logic                 RX_BUSY
`ifdef UART_RX_PARITY_EN
   , output logic               RX_PARITY_ERR
`endif
);

   localparam int unsigned DIV = uart_div(CLK_HZ, BAUD);

   logic rxs_meta_q, rxs_q;
   logic tick, restart_c, commit_c;

   rx_state_t            state_q, state_d;
   logic [3:0]           scnt_q, scnt_d;
   logic [2:0]           bidx_q, bidx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_q, par_d;
   logic                 perr_q, perr_d;
   logic                 par_bad_c;
`endif

   // Two-flop synchronizer; resets to the idle line level.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         rxs_meta_q <= 1'b1;
         rxs_q      <= 1'b1;
      end else begin
         rxs_meta_q <= UART_RXD;
         rxs_q      <= rxs_meta_q;
      end
   end

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .restart  (restart_c),
      .tick     (tick)
   );

`ifdef UART_RX_PARITY_EN
   // Data XOR parity bit must equal 0 for even parity, 1 for odd.
   assign par_bad_c = ((^shift_q) ^ par_q) != PARITY_ODD;
`endif

   // Receive FSM, shift register and holding-register handshake.
   always_comb begin
      state_d   = state_q;
      scnt_d    = scnt_q;
      bidx_d    = bidx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = valid_q;
      ovr_d     = ovr_q;
      ferr_d    = 1'b0;
      restart_c = 1'b0;
      commit_c  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d     = par_q;
      perr_d    = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (!rxs_q) begin
               state_d   = ST_START;
               scnt_d    = '0;
               restart_c = 1'b1;
            end
         end
         ST_START: begin
            if (tick) begin
               if (scnt_q == 4'(MID_SAMPLE)) begin
                  if (rxs_q) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_DATA;
                     scnt_d  = '0;
                     bidx_d  = '0;
                  end
               end else begin
                  scnt_d = scnt_q + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               scnt_d = scnt_q + 4'd1;
               if (scnt_q == 4'(OVERSAMPLE - 1)) begin
                  shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                  if (bidx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end else begin
                     bidx_d = bidx_q + 3'd1;
                  end
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               scnt_d = scnt_q + 4'd1;
               if (scnt_q == 4'(OVERSAMPLE - 1)) begin
                  par_d   = rxs_q;
                  state_d = ST_STOP;
               end
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               scnt_d = scnt_q + 4'd1;
               if (scnt_q == 4'(OVERSAMPLE - 1)) begin
                  if (rxs_q) begin
                     // Return to idle at mid stop bit so the next start edge is caught early.
                     state_d  = ST_IDLE;
                     commit_c = 1'b1;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = ST_WAIT_IDLE;
                  end
`ifdef UART_RX_PARITY_EN
                  if (par_bad_c) begin
                     perr_d   = 1'b1;
                     commit_c = 1'b0;
                  end
`endif
               end
            end
         end
         ST_WAIT_IDLE: begin
            if (rxs_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Holding register: a commit with ack in the same cycle replaces the old byte.
      if (commit_c) begin
         if (!valid_q || RX_ACK) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (RX_ACK) ovr_d = 1'b0;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && RX_ACK) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         scnt_q  <= '0;
         bidx_q  <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
         bidx_q  <= bidx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
         busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign RX_DATA      = data_q;
   assign RX_VALID     = valid_q;
   assign RX_FRAME_ERR = ferr_q;
   assign RX_OVERRUN   = ovr_q;
   assign RX_BUSY      = busy_q;
`ifdef UART_RX_PARITY_EN
   assign RX_PARITY_ERR = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench for uart_rx_core at DIV=1 (16 clocks per bit).
// Optional feature macro: UART_RX_PARITY_EN enables the parity scenarios.
module tb_uart_rx_core;

   logic       CLOCK_50 = 1'b0;
   logic       RESET_N  = 1'b0;
   logic       UART_RXD = 1'b1;
   logic       RX_ACK   = 1'b0;
   logic [7:0] RX_DATA;
   logic       RX_VALID, RX_FRAME_ERR, RX_OVERRUN, RX_BUSY;
`ifdef UART_RX_PARITY_EN
   logic       RX_PARITY_ERR;
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   // Negedge index (from the start-bit negedge) at which RX_VALID first reads high.
   localparam int LAT = 16 * (NB - 1) + 11;

   int vectors     = 0;
   int miscompares = 0;
   int fe_cnt = 0, fe_len = 0, pe_cnt = 0;
   logic [7:0] exp_q[$];

   uart_rx_core #(
      .CLK_HZ(1600000), .BAUD(100000)
`ifdef UART_RX_PARITY_EN
      , .PARITY_ODD(1'b0)
`endif
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .RESET_N      (RESET_N),
      .UART_RXD     (UART_RXD),
      .RX_DATA      (RX_DATA),
      .RX_VALID     (RX_VALID),
      .RX_ACK       (RX_ACK),
      .RX_FRAME_ERR (RX_FRAME_ERR),
      .RX_OVERRUN   (RX_OVERRUN),
      .RX_BUSY      (RX_BUSY)
`ifdef UART_RX_PARITY_EN
      , .RX_PARITY_ERR (RX_PARITY_ERR)
`endif
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one frame; par_flip corrupts the even parity bit; abort_at >= 0 stops early.
   task automatic send(input logic [7:0] b, input logic stop, input logic par_flip,
                       input int abort_at, input bit lat);
      logic [10:0] fr;
      fr       = '1;
      fr[0]    = 1'b0;
      fr[8:1]  = b;
`ifdef UART_RX_PARITY_EN
      fr[9]    = (^b) ^ par_flip;
      fr[10]   = stop;
`else
      fr[9]    = stop;
      if (par_flip) fr[10] = 1'b1;
`endif
      for (int c = 0; c < 16 * NB; c++) begin
         @(negedge CLOCK_50);
         UART_RXD = fr[c / 16];
         if (lat && c == LAT - 1) chk("latency_pre", 32'(RX_VALID), 32'd0);
         if (lat && c == LAT)     chk("latency_valid", 32'(RX_VALID), 32'd1);
         if (c == abort_at) return;
      end
   endtask

   task automatic idle(input int n);
      UART_RXD = 1'b1;
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic pulse_ack;
      @(negedge CLOCK_50);
      RX_ACK = 1'b1;
      @(negedge CLOCK_50);
      RX_ACK = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_data"},  32'(RX_DATA),      32'h00);
      chk({tag, "_valid"}, 32'(RX_VALID),     32'd0);
      chk({tag, "_ferr"},  32'(RX_FRAME_ERR), 32'd0);
      chk({tag, "_ovr"},   32'(RX_OVERRUN),   32'd0);
      chk({tag, "_busy"},  32'(RX_BUSY),      32'd0);
   endtask

   // Monitor: pop the scoreboard on each RX_VALID rise; count error pulses.
   initial begin
      logic pv, pf, pp;
      pv = 1'b0; pf = 1'b0; pp = 1'b0;
      forever begin
         @(negedge CLOCK_50);
         if (RX_VALID && !pv) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_valid: got data %0h with empty scoreboard at %0t",
                        RX_DATA, $time);
            end else begin
               chk("rx_data", 32'(RX_DATA), 32'(exp_q.pop_front()));
            end
         end
         if (RX_FRAME_ERR) fe_len++;
         if (RX_FRAME_ERR && !pf) fe_cnt++;
         pv = RX_VALID;
         pf = RX_FRAME_ERR;
`ifdef UART_RX_PARITY_EN
         if (RX_PARITY_ERR && !pp) pe_cnt++;
         pp = RX_PARITY_ERR;
`endif
      end
   end

   initial begin
      int fe0, fl0;
      repeat (3) @(negedge CLOCK_50);
      chk_reset_vals("reset");
      RESET_N = 1'b1;
      idle(8);

      // Single byte, no ack, with latency check.
      exp_q.push_back(8'hA5);
      send(8'hA5, 1'b1, 1'b0, -1, 1'b1);
      idle(16);
      chk("a5_valid", 32'(RX_VALID),     32'd1);
      chk("a5_data",  32'(RX_DATA),      32'hA5);
      chk("a5_ferr",  32'(fe_cnt),       32'd0);
      chk("a5_ovr",   32'(RX_OVERRUN),   32'd0);
      chk("a5_busy",  32'(RX_BUSY),      32'd0);
      pulse_ack();
      chk("a5_ack_valid", 32'(RX_VALID), 32'd0);

      // Overrun: second byte dropped while the first is unacknowledged.
      exp_q.push_back(8'h3C);
      send(8'h3C, 1'b1, 1'b0, -1, 1'b0);
      send(8'h81, 1'b1, 1'b0, -1, 1'b0);
      idle(16);
      chk("ovr_data",  32'(RX_DATA),    32'h3C);
      chk("ovr_flag",  32'(RX_OVERRUN), 32'd1);
      chk("ovr_valid", 32'(RX_VALID),   32'd1);
      pulse_ack();
      chk("ovr_ack_valid", 32'(RX_VALID),   32'd0);
      chk("ovr_ack_flag",  32'(RX_OVERRUN), 32'd0);

      // False start: 4-clock glitch.
      fe0 = fe_cnt;
      @(negedge CLOCK_50);
      UART_RXD = 1'b0;
      repeat (4) @(negedge CLOCK_50);
      UART_RXD = 1'b1;
      chk("glitch_busy", 32'(RX_BUSY), 32'd1);
      idle(12);
      chk("glitch_idle",  32'(RX_BUSY),  32'd0);
      chk("glitch_valid", 32'(RX_VALID), 32'd0);
      chk("glitch_ferr",  32'(fe_cnt),   32'(fe0));

      // Framing error then line held low; recovery byte follows.
      fe0 = fe_cnt;
      fl0 = fe_len;
      send(8'h55, 1'b0, 1'b0, -1, 1'b0);
      repeat (40) @(negedge CLOCK_50);
      chk("fe_pulses", 32'(fe_cnt - fe0), 32'd1);
      chk("fe_width",  32'(fe_len - fl0), 32'd1);
      chk("fe_valid",  32'(RX_VALID),     32'd0);
      chk("fe_wait",   32'(RX_BUSY),      32'd1);
      idle(8);
      chk("fe_recover", 32'(RX_BUSY), 32'd0);
      exp_q.push_back(8'h0F);
      send(8'h0F, 1'b1, 1'b0, -1, 1'b0);
      idle(16);
      chk("0f_data",  32'(RX_DATA),  32'h0F);
      chk("0f_valid", 32'(RX_VALID), 32'd1);

      // Asynchronous reset during data bit 3 of 0xFF.
      send(8'hFF, 1'b1, 1'b0, 70, 1'b0);
      #1 RESET_N = 1'b0;
      #1 chk_reset_vals("midrst");
      repeat (3) @(negedge CLOCK_50);
      RESET_N = 1'b1;
      idle(32);
      exp_q.push_back(8'h12);
      send(8'h12, 1'b1, 1'b0, -1, 1'b0);
      idle(16);
      chk("12_data",  32'(RX_DATA),  32'h12);
      chk("12_valid", 32'(RX_VALID), 32'd1);
      pulse_ack();

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x07 needs parity bit 1.
      fe0 = pe_cnt;
      send(8'h07, 1'b1, 1'b1, -1, 1'b0);
      idle(16);
      chk("par_err_pulse", 32'(pe_cnt - fe0), 32'd1);
      chk("par_err_valid", 32'(RX_VALID),     32'd0);
      exp_q.push_back(8'h07);
      send(8'h07, 1'b1, 1'b0, -1, 1'b0);
      idle(16);
      chk("par_ok_data",  32'(RX_DATA),  32'h07);
      chk("par_ok_valid", 32'(RX_VALID), 32'd1);
      chk("par_ok_nerr",  32'(pe_cnt - fe0), 32'd1);
`endif

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
